// File: rtl/cat_fifo_nch.sv
// Ping-pong concatenation buffer: NumCh channels each fill one segment of a vector,
// and the completed vector drains as fixed-width read chunks while the next one fills.
module cat_fifo_nch #(
    parameter int unsigned NBits            = 8,
    parameter int unsigned NumCh            = 2,
    parameter int unsigned ChElements       = 4,
    parameter int unsigned ElementsPerWrite = 2,
    parameter int unsigned ElementsPerRead  = 4
) (
    input  logic                                               clk_in,
    input  logic                                               rst_in,
    input  logic [NumCh-1:0]                                   wr_en,
    input  logic [NumCh-1:0][ElementsPerWrite-1:0][NBits-1:0]  wr_data,
    output logic [NumCh-1:0]                                   wr_ready,
    input  logic                                               rd_en,
    output logic [ElementsPerRead-1:0][NBits-1:0]              rd_data,
    output logic                                               cat_valid,
    output logic                                               rd_last,
    output logic                                               wr_overflow,
    output logic                                               rd_underflow
);

    localparam int unsigned Total    = NumCh * ChElements;
    localparam int unsigned WrBeats  = ChElements / ElementsPerWrite;
    localparam int unsigned RdChunks = Total / ElementsPerRead;
    localparam int unsigned Depth    = 2 * Total;
    localparam int unsigned AW       = $clog2(Depth);
    localparam int unsigned WpW      = $clog2(WrBeats) + 1;
    localparam int unsigned RpW      = $clog2(RdChunks) + 1;

    localparam logic [0:0] WrFill  = 1'b0;
    localparam logic [0:0] WrHold  = 1'b1;
    localparam logic [0:0] RdIdle  = 1'b0;
    localparam logic [0:0] RdDrain = 1'b1;

    logic [0:0]                 wr_state_q, wr_state_d;
    logic [0:0]                 rd_state_q, rd_state_d;
    logic                       bank_q, bank_d;
    logic [NumCh-1:0][WpW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [NumCh-1:0]           done_q, done_d;
    logic [RpW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;
    logic [NumCh-1:0]           wr_acc;
    logic                       all_done;
    logic                       swap;
    logic [NumCh-1:0][AW-1:0]   wr_addr;
    logic [AW-1:0]              rd_addr;
    logic [NBits-1:0]           mem_q [Depth];

    assign cat_valid    = (rd_state_q == RdDrain);
    assign rd_last      = cat_valid && (rd_ptr_q == RpW'(RdChunks - 1));
    assign wr_ready     = ~done_q;
    assign wr_overflow  = ovf_q;
    assign rd_underflow = unf_q;

    always_comb begin
        wr_acc   = wr_en & ~done_q;
        wr_ptr_d = wr_ptr_q;
        done_d   = done_q;
        for (int c = 0; c < int'(NumCh); c++) begin
            if (wr_acc[c]) begin
                if (wr_ptr_q[c] == WpW'(WrBeats - 1)) begin
                    done_d[c]   = 1'b1;
                    wr_ptr_d[c] = '0;
                end else begin
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                end
            end
        end
        all_done = &done_d;
        // Swap may coincide with the last write beat and/or the final read of the old vector.
        swap = ((wr_state_q == WrHold) || all_done) &&
               ((rd_state_q == RdIdle) || (rd_en && rd_last));

        wr_state_d = all_done ? WrHold : WrFill;
        bank_d     = bank_q;
        if (swap) begin
            wr_state_d = WrFill;
            done_d     = '0;
            wr_ptr_d   = '0;
            bank_d     = !bank_q;
        end

        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        if ((rd_state_q == RdDrain) && rd_en) begin
            if (rd_last) begin
                rd_ptr_d   = '0;
                rd_state_d = RdIdle;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
        if (swap) begin
            rd_state_d = RdDrain;
            rd_ptr_d   = '0;
        end

        ovf_d = ovf_q | (|(wr_en & done_q));
        unf_d = unf_q | (rd_en & ~cat_valid);
    end

    always_comb begin
        for (int c = 0; c < int'(NumCh); c++) begin
            wr_addr[c] = AW'(32'(bank_q) * Total + 32'(c) * ChElements
                             + 32'(wr_ptr_q[c]) * ElementsPerWrite);
        end
        rd_addr = AW'(32'(!bank_q) * Total + 32'(rd_ptr_q) * ElementsPerRead);
        for (int e = 0; e < int'(ElementsPerRead); e++) begin
            rd_data[e] = mem_q[rd_addr + AW'(e)];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_state_q <= WrFill;
            rd_state_q <= RdIdle;
            bank_q     <= 1'b0;
            wr_ptr_q   <= '0;
            done_q     <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            bank_q     <= bank_d;
            wr_ptr_q   <= wr_ptr_d;
            done_q     <= done_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is never cleared; unread contents are simply overwritten.
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < int'(NumCh); c++) begin
            for (int e = 0; e < int'(ElementsPerWrite); e++) begin
                if (wr_acc[c] && !rst_in) begin
                    mem_q[wr_addr[c] + AW'(e)] <= wr_data[c][e];
                end
            end
        end
    end

endmodule

// File: tb/tb_cat_fifo_nch.sv
// Randomised and directed bench for cat_fifo_nch against a vector-level queue model.
module tb_cat_fifo_nch;

    localparam int NBits  = 8;
    localparam int NumCh  = 2;
    localparam int ChE    = 4;
    localparam int EPW    = 2;
    localparam int EPR    = 4;
    localparam int Total  = NumCh * ChE;
    localparam int Beats  = ChE / EPW;
    localparam int Chunks = Total / EPR;

    logic                                  clk_in = 1'b0;
    logic                                  rst_in;
    logic [NumCh-1:0]                      wr_en;
    logic [NumCh-1:0][EPW-1:0][NBits-1:0]  wr_data;
    logic [NumCh-1:0]                      wr_ready;
    logic                                  rd_en;
    logic [EPR-1:0][NBits-1:0]             rd_data;
    logic                                  cat_valid;
    logic                                  rd_last;
    logic                                  wr_overflow;
    logic                                  rd_underflow;

    cat_fifo_nch #(
        .NBits(NBits), .NumCh(NumCh), .ChElements(ChE),
        .ElementsPerWrite(EPW), .ElementsPerRead(EPR)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .cat_valid(cat_valid),
        .rd_last(rd_last), .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    // Model: per-channel beat counts into the filling vector, plus the vector being read.
    int         cnt [NumCh];
    logic [7:0] fill [Total];
    logic [7:0] rvec [Total];
    bit         act;
    int         k;
    bit         m_ovf, m_unf;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic [NumCh-1:0] we, input logic [NumCh*EPW*NBits-1:0] wd,
                         input logic re, input logic rst);
        bit full;
        if (rst) begin
            for (int c = 0; c < NumCh; c++) cnt[c] = 0;
            act = 0; k = 0; m_ovf = 0; m_unf = 0;
            return;
        end
        for (int c = 0; c < NumCh; c++) begin
            if (we[c]) begin
                if (cnt[c] >= Beats) m_ovf = 1;
                else begin
                    for (int e = 0; e < EPW; e++)
                        fill[c*ChE + cnt[c]*EPW + e] = wd[(c*EPW + e)*NBits +: NBits];
                    cnt[c]++;
                end
            end
        end
        if (re) begin
            if (!act) m_unf = 1;
            else if (k == Chunks - 1) begin act = 0; k = 0; end
            else k++;
        end
        full = 1;
        for (int c = 0; c < NumCh; c++) if (cnt[c] != Beats) full = 0;
        if (full && !act) begin
            for (int i = 0; i < Total; i++) rvec[i] = fill[i];
            act = 1; k = 0;
            for (int c = 0; c < NumCh; c++) cnt[c] = 0;
        end
    endtask

    task automatic check_all();
        logic [NumCh-1:0] r;
        logic [EPR*NBits-1:0] ed;
        for (int c = 0; c < NumCh; c++) r[c] = (cnt[c] < Beats);
        chk("cat_valid", cat_valid, act);
        chk("rd_last", rd_last, act && (k == Chunks - 1));
        chk("wr_ready", wr_ready, r);
        chk("wr_overflow", wr_overflow, m_ovf);
        chk("rd_underflow", rd_underflow, m_unf);
        if (act) begin
            for (int e = 0; e < EPR; e++) ed[e*NBits +: NBits] = rvec[k*EPR + e];
            chk("rd_data", rd_data, ed);
        end
    endtask

    task automatic tick(input logic [NumCh-1:0] we, input logic [NumCh*EPW*NBits-1:0] wd,
                        input logic re, input logic rst);
        rst_in = rst; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk_in);
        model(we, wd, re, rst);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] mk(input int a0, input int a1, input int b0, input int b1);
        return {8'(b1), 8'(b0), 8'(a1), 8'(a0)};
    endfunction

    initial begin
        rst_in = 1'b1; wr_en = '0; wr_data = '0; rd_en = 1'b0;
        tick(2'b00, 0, 0, 1);
        tick(2'b00, 0, 0, 1);

        // Underflow straight after reset
        tick(2'b00, 0, 1, 0);
        chk("unf_set", rd_underflow, 1);
        chk("unf_novalid", cat_valid, 0);

        // Basic concat
        tick(2'b01, mk(1, 2, 0, 0), 0, 0);
        tick(2'b01, mk(3, 4, 0, 0), 0, 0);
        tick(2'b10, mk(0, 0, 5, 6), 0, 0);
        tick(2'b10, mk(0, 0, 7, 8), 0, 0);
        chk("basic_valid", cat_valid, 1);
        chk("basic_c0", rd_data, 32'h04030201);
        tick(2'b00, 0, 1, 0);
        chk("basic_c1", rd_data, 32'h08070605);
        chk("basic_last", rd_last, 1);
        tick(2'b00, 0, 1, 0);
        chk("basic_empty", cat_valid, 0);

        // Interleave and simultaneous writes
        tick(2'b11, mk(1, 2, 5, 6), 0, 0);
        tick(2'b10, mk(0, 0, 7, 8), 0, 0);
        chk("il_ready", wr_ready, 2'b01);
        tick(2'b01, mk(3, 4, 0, 0), 0, 0);
        chk("il_c0", rd_data, 32'h04030201);

        // Ping-pong: B completes while A drains
        tick(2'b11, mk(9, 10, 13, 14), 0, 0);
        tick(2'b11, mk(11, 12, 15, 16), 0, 0);
        tick(2'b00, 0, 1, 0);
        tick(2'b00, 0, 1, 0);
        chk("pp_valid", cat_valid, 1);
        chk("pp_b0", rd_data, 32'h0c0b0a09);
        tick(2'b00, 0, 1, 0);
        chk("pp_b1", rd_data, 32'h100f0e0d);
        tick(2'b00, 0, 1, 0);

        // Backpressure and overflow
        tick(2'b00, 0, 0, 1);
        for (int v = 0; v < 3; v++)
            for (int b = 0; b < Beats; b++) tick(2'b11, $urandom & 32'h3f3f3f3f, 0, 0);
        chk("bp_ready", wr_ready, 2'b00);
        tick(2'b01, mk(99, 99, 0, 0), 0, 0);
        chk("ovf_set", wr_overflow, 1);
        for (int i = 0; i < 2 * Chunks; i++) tick(2'b00, 0, 1, 0);

        // Mid-operation reset with a vector draining and another held
        tick(2'b00, 0, 0, 1);
        tick(2'b11, mk(21, 22, 25, 26), 0, 0);
        tick(2'b11, mk(23, 24, 27, 28), 0, 0);
        tick(2'b00, 0, 1, 0);
        tick(2'b11, mk(31, 32, 35, 36), 0, 0);
        tick(2'b11, mk(33, 34, 37, 38), 0, 0);
        tick(2'b00, 0, 0, 1);
        chk("mr_valid", cat_valid, 0);
        chk("mr_ready", wr_ready, 2'b11);
        chk("mr_flags", {wr_overflow, rd_underflow}, 2'b00);
        tick(2'b11, mk(1, 2, 5, 6), 0, 0);
        tick(2'b11, mk(3, 4, 7, 8), 0, 0);
        chk("mr_c0", rd_data, 32'h04030201);
        tick(2'b00, 0, 1, 0);
        chk("mr_c1", rd_data, 32'h08070605);
        tick(2'b00, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            tick(2'($urandom), $urandom, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 399) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
